// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - MemControl encodings, FSM states and access-size decode
package mem_access_unit_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LW  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LHU = 4'd3;
  localparam logic [3:0] MEM_LB  = 4'd4;
  localparam logic [3:0] MEM_LBU = 4'd5;
  localparam logic [3:0] MEM_SW  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SB  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_t;

  function automatic size_t access_size(input logic [3:0] ctl);
    case (ctl)
      MEM_LB, MEM_LBU, MEM_SB: access_size = SZ_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: access_size = SZ_HALF;
      MEM_LW, MEM_SW:          access_size = SZ_WORD;
      default:                 access_size = SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian byte-lane steering, alignment check and load extension
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  mem_control,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] load_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    case (addr_lo)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
    rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be       = 4'b0000;
    wdata    = store_data;
    misalign = 1'b0;
    case (access_size(mem_control))
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        be       = 4'b0011 << addr_lo;
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
      end
      SZ_WORD: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_ext = 32'h0;
    case (mem_control)
      MEM_LW:  load_ext = rdata;
      MEM_LH:  load_ext = {{16{rd_half[15]}}, rd_half};
      MEM_LHU: load_ext = {16'h0, rd_half};
      MEM_LB:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      MEM_LBU: load_ext = {24'h0, rd_byte};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: one req/ack bus cycle per access, stalls pipeline
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_result,
  input  logic [31:0] RD2,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [3:0]  MemControl,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        addr_err,
  output logic        bus_err
);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [3:0]  ctl_q;
  logic [1:0]  alo_q;
  logic        access, start, timed_out;
  logic [3:0]  sel_ctl;
  logic [1:0]  sel_alo;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;
  logic        lane_misalign;

  assign access    = (MemRead | MemWrite) && (MemControl != MEM_NOP);
  assign timed_out = (wait_cnt == 8'(TIMEOUT - 1));

  // Steer from live inputs while deciding in IDLE; from the captured access afterwards.
  assign sel_ctl = (state == IDLE) ? MemControl       : ctl_q;
  assign sel_alo = (state == IDLE) ? ALU_result[1:0] : alo_q;

  mem_lane_align u_lane (
    .addr_lo     (sel_alo),
    .mem_control (sel_ctl),
    .store_data  (RD2),
    .rdata       (bus_rdata),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .misalign    (lane_misalign),
    .load_ext    (lane_load)
  );

  assign start = (state == IDLE) && access && !lane_misalign;

  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mem_stall = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus_req   = 1'b1;
        mem_stall = 1'b1;
        if (bus_ack || timed_out) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      load_data <= 32'h0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
      ctl_q     <= MEM_NOP;
      alo_q     <= 2'd0;
    end else begin
      state    <= state_nxt;
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wait_cnt  <= 8'd0;
            bus_we    <= MemWrite;
            bus_be    <= lane_be;
            bus_addr  <= {ALU_result[31:2], 2'b00};
            bus_wdata <= lane_wdata;
            ctl_q     <= MemControl;
            alo_q     <= ALU_result[1:0];
          end else if (access) begin
            addr_err <= 1'b1;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            if (!bus_we) load_data <= lane_load;
            bus_we <= 1'b0;
            bus_be <= 4'b0000;
          end else if (timed_out) begin
            bus_err <= 1'b1;
            if (!bus_we) load_data <= 32'h0;
            bus_we <= 1'b0;
            bus_be <= 4'b0000;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench: directed loads/stores, misalign, timeout, reset mid-access
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int K_XFER = 0;
  localparam int K_AERR = 1;
  localparam int K_TMO  = 2;
  localparam int K_RST  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALU_result, RD2, bus_rdata;
  logic        MemRead, MemWrite, bus_ack;
  logic [3:0]  MemControl;
  logic        bus_req, bus_we, mem_stall, addr_err, bus_err;
  logic [31:0] bus_addr, bus_wdata, load_data;
  logic [3:0]  bus_be;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ALU_result(ALU_result), .RD2(RD2),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemControl(MemControl),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .load_data(load_data),
    .mem_stall(mem_stall), .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic        rd, wr;
    logic [3:0]  ctl;
    logic [31:0] addr, rd2, rdata;
    int          waits;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata, e_load;
    logic        e_berr;
    int          e_req, e_stall;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void add(int kind, logic rd, logic wr, logic [3:0] ctl, logic [31:0] addr,
                              logic [31:0] rd2, logic [31:0] rdata, int waits,
                              logic [31:0] e_addr, logic [3:0] e_be, logic e_we,
                              logic [31:0] e_wdata, logic [31:0] e_load, logic e_berr);
    vec_t v;
    v.kind = kind; v.rd = rd; v.wr = wr; v.ctl = ctl; v.addr = addr; v.rd2 = rd2;
    v.rdata = rdata; v.waits = waits; v.e_addr = e_addr; v.e_be = e_be; v.e_we = e_we;
    v.e_wdata = e_wdata; v.e_load = e_load; v.e_berr = e_berr;
    v.e_req   = (kind == K_TMO) ? 16 : waits + 1;
    v.e_stall = v.e_req + 1;
    vecs.push_back(v);
  endfunction

  // Monitor: completion is the first cycle bus_req is low after being high.
  int          req_cnt = 0, stall_cnt = 0;
  logic        prev_req = 1'b0, early_err = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  always @(negedge clk) begin
    vec_t e;
    if (mem_stall) stall_cnt++;
    if (bus_req) begin
      req_cnt++;
      cap_addr = bus_addr; cap_be = bus_be; cap_we = bus_we; cap_wdata = bus_wdata;
      if (bus_err) early_err = 1'b1;
    end else if (prev_req) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: completion with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        chk("done_kind_not_aerr", 32'(e.kind != K_AERR), 32'd1);
        chk("bus_addr", cap_addr, e.e_addr);
        chk("bus_be", 32'(cap_be), 32'(e.e_be));
        chk("bus_we", 32'(cap_we), 32'(e.e_we));
        if (e.e_we) chk("bus_wdata", cap_wdata, e.e_wdata);
        chk("load_data", load_data, e.e_load);
        chk("bus_err", 32'(bus_err), 32'(e.e_berr));
        chk("bus_err_early", 32'(early_err), 32'd0);
        chk("req_cycles", 32'(req_cnt), 32'(e.e_req));
        chk("stall_cycles", 32'(stall_cnt), 32'(e.e_stall));
        chk("stall_in_done", 32'(mem_stall), 32'd0);
      end
      req_cnt = 0; stall_cnt = 0; early_err = 1'b0;
    end
    if (addr_err) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty_aerr: addr_err with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        chk("aerr_kind", 32'(e.kind), 32'(K_AERR));
        chk("aerr_load_kept", load_data, e.e_load);
        chk("aerr_no_req", 32'(req_cnt), 32'd0);
        chk("aerr_no_stall", 32'(stall_cnt), 32'd0);
      end
    end
    prev_req = bus_req;
  end

  task automatic clear_inputs();
    MemRead = 1'b0; MemWrite = 1'b0; MemControl = MEM_NOP; ALU_result = 32'h0; RD2 = 32'h0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus_req) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_wait: bus_req never rose (got 0 expected 1)");
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    exp_q.push_back(v);
    MemRead = v.rd; MemWrite = v.wr; MemControl = v.ctl; ALU_result = v.addr; RD2 = v.rd2;
    if (v.kind == K_AERR) begin
      @(negedge clk);
      chk("aerr_stall_low", 32'(mem_stall), 32'd0);
      chk("aerr_req_low", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
      clear_inputs();
      @(posedge clk); #1;
      @(negedge clk);
      chk("aerr_one_cycle", 32'(addr_err), 32'd0);
    end else begin
      wait_req(ok);
      if (ok) begin
        if (v.kind == K_TMO) begin
          for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!bus_req) break;
          end
          @(posedge clk); #1;
          clear_inputs();
          @(negedge clk);
          chk("bus_err_one_cycle", 32'(bus_err), 32'd0);
        end else begin
          repeat (v.waits) begin @(posedge clk); #1; end
          bus_ack = 1'b1; bus_rdata = v.rdata;
          @(posedge clk); #1;
          bus_ack = 1'b0; bus_rdata = 32'h5A5A_A5A5;
          @(posedge clk); #1;
          clear_inputs();
        end
      end else begin
        void'(exp_q.pop_back());
        clear_inputs();
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    bit ok;
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    //  kind    rd wr ctl      addr          rd2           rdata         w   e_addr        be       we  e_wdata       e_load        berr
    add(K_XFER, 1, 0, MEM_LW,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 32'h0000_0100, 4'b1111, 0, 32'h0,        32'hDEAD_BEEF, 0);
    add(K_XFER, 1, 0, MEM_LB,  32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 32'h0000_0100, 4'b1000, 0, 32'h0,        32'hFFFF_FF80, 0);
    add(K_XFER, 1, 0, MEM_LBU, 32'h0000_0103, 32'h0,        32'h80FF_1234, 2, 32'h0000_0100, 4'b1000, 0, 32'h0,        32'h0000_0080, 0);
    add(K_XFER, 1, 0, MEM_LH,  32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 32'h0000_0100, 4'b1100, 0, 32'h0,        32'hFFFF_80FF, 0);
    add(K_XFER, 1, 0, MEM_LHU, 32'h0000_0100, 32'h0,        32'h80FF_1234, 1, 32'h0000_0100, 4'b0011, 0, 32'h0,        32'h0000_1234, 0);
    add(K_XFER, 1, 0, MEM_LB,  32'h0000_0101, 32'h0,        32'h80FF_1234, 0, 32'h0000_0100, 4'b0010, 0, 32'h0,        32'h0000_0012, 0);
    add(K_XFER, 0, 1, MEM_SB,  32'h0000_0101, 32'h0000_00AB, 32'hFFFF_FFFF, 0, 32'h0000_0100, 4'b0010, 1, 32'hABAB_ABAB, 32'h0000_0012, 0);
    add(K_XFER, 0, 1, MEM_SH,  32'h0000_0102, 32'h0000_1234, 32'hFFFF_FFFF, 1, 32'h0000_0100, 4'b1100, 1, 32'h1234_1234, 32'h0000_0012, 0);
    add(K_XFER, 1, 1, MEM_SW,  32'h0000_0104, 32'hCAFE_F00D, 32'hFFFF_FFFF, 3, 32'h0000_0104, 4'b1111, 1, 32'hCAFE_F00D, 32'h0000_0012, 0);
    add(K_AERR, 1, 0, MEM_LW,  32'h0000_0102, 32'h0,        32'h0,         0, 32'h0,        4'b0000, 0, 32'h0,        32'h0000_0012, 0);
    add(K_AERR, 0, 1, MEM_SH,  32'h0000_0101, 32'h0000_5555, 32'h0,        0, 32'h0,        4'b0000, 0, 32'h0,        32'h0000_0012, 0);
    add(K_TMO,  1, 0, MEM_LW,  32'h0000_0200, 32'h0,        32'h0,        -1, 32'h0000_0200, 4'b1111, 0, 32'h0,        32'h0000_0000, 1);
    add(K_XFER, 1, 0, MEM_LW,  32'h0000_0204, 32'h0,        32'h1357_9BDF, 0, 32'h0000_0204, 4'b1111, 0, 32'h0,        32'h1357_9BDF, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // MemRead with MEM_NOP is not an access.
    MemRead = 1'b1; MemControl = MEM_NOP; ALU_result = 32'h0000_0102;
    @(negedge clk);
    chk("nop_no_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("nop_no_aerr", 32'(addr_err), 32'd0);
    chk("nop_no_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;

    // Reset during the third BUSY cycle, then a stray ack.
    r.kind = K_RST; r.e_addr = 32'h0000_0300; r.e_be = 4'b1111; r.e_we = 1'b0; r.e_wdata = 32'h0;
    r.e_load = 32'h0; r.e_berr = 1'b0; r.e_req = 3; r.e_stall = 4; r.waits = 0;
    r.rd = 1'b1; r.wr = 1'b0; r.ctl = MEM_LW; r.addr = 32'h0000_0300; r.rd2 = 32'h0; r.rdata = 32'h0;
    exp_q.push_back(r);
    MemRead = 1'b1; MemControl = MEM_LW; ALU_result = 32'h0000_0300;
    wait_req(ok);
    if (!ok) void'(exp_q.pop_back());
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h55AA_55AA;
    @(negedge clk);
    chk("rst_mid_req_low", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored", load_data, 32'h0);
    chk("late_ack_no_req", 32'(bus_req), 32'd0);
    chk("late_ack_no_stall", 32'(mem_stall), 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit that sits directly downstream of the EX/MEM pipeline register.
- Takes the registered address (ALU result), store data, MemRead/MemWrite and MemControl, and runs one bus transaction per load/store over a req/ack data bus.
- Handles byte/halfword lane steering plus sign/zero extension, and stalls the pipeline until the access completes.
- Loaded word goes to the MEM/WB register.

Parameters:
- TIMEOUT, 16, cycles waiting for bus_ack before aborting with bus_err; range 2..255.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ALU_result  in  32  byte address from EX/MEM
- RD2  in  32  store data from EX/MEM
- MemRead  in  1  load request
- MemWrite  in  1  store request
- MemControl  in  4  access type (MEM_* encoding)
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  1=write
- bus_addr  out  32  word address {ALU_result[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion
- load_data  out  32  extended load result (registered)
- mem_stall  out  1  freeze PC/IF_ID/ID_EX/EX_MEM
- addr_err  out  1  one-cycle misalignment pulse
- bus_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset: bus_req=0, bus_we=0, bus_be=0, load_data=0, addr_err=0, bus_err=0, timeout counter=0, state=IDLE. mem_stall=0 in IDLE with no access.
- Reset mid-transaction: at the reset edge, state goes to IDLE and bus_req drops. A late bus_ack is ignored.
- access = (MemRead|MemWrite) && MemControl!=MEM_NOP.
- Direction: write if MemWrite, otherwise read. If both are high, write wins.
- Alignment:
  - halfword needs addr[0]=0
  - word needs addr[1:0]=0
  - misaligned: no bus cycle, addr_err pulses for one cycle, mem_stall=0, load_data unchanged, state stays IDLE.
- Lanes are little-endian.
  - be: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'hF.
  - wdata: SB = {4{RD2[7:0]}}; SH = {2{RD2[15:0]}}; SW = RD2.
- FSM IDLE/BUSY/DONE:
  - IDLE: aligned access → mem_stall=1 (combinational, same cycle); next state BUSY; counter cleared.
  - BUSY:
    - bus_req=1; bus_we/bus_addr/bus_be/bus_wdata stable; mem_stall=1.
    - On bus_ack: reads capture the extended lane into load_data; writes leave load_data unchanged. Next state DONE.
    - No ack: counter increments. When counter reaches TIMEOUT-1 with no ack: bus_err pulses, load_data=0 for reads, next state DONE.
  - DONE: bus_req=0, mem_stall=0. The pipeline advances at this edge. Next state IDLE.
- Latency: a zero-wait-state access (ack in the first BUSY cycle) stalls 2 cycles; each ack wait state adds one cycle.
- Load extraction:
  - LB/LBU take byte addr[1:0]; LH/LHU take half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Back-to-back accesses: there is always one IDLE cycle after DONE. The next access is seen there and stalls immediately.
- bus_ack outside BUSY is ignored.

Decomposition:
- Shared encoding include holds the MemControl constants: MEM_NOP=0, MEM_LW=1, MEM_LH=2, MEM_LHU=3, MEM_LB=4, MEM_LBU=5, MEM_SW=6, MEM_SH=7, MEM_SB=8, plus state codes IDLE=0, BUSY=1, DONE=2.
- Natural sub-module: mem_lane_align, combinational. It generates be/wdata/misalign from addr+MemControl+RD2 and extracts/extends rdata. The FSM and counter stay in the top.

Test Plan:
- LW addr 0x100, bus_rdata=0xDEADBEEF, ack in first BUSY cycle → bus_be=F, mem_stall high 2 cycles, load_data=0xDEADBEEF.
- LB addr 0x103, rdata=0x80FF1234 → bus_addr=0x100, load_data=0xFFFFFF80. LBU same → 0x00000080. LH addr 0x102 → 0xFFFF80FF.
- SB addr 0x101, RD2=0x000000AB → bus_we=1, bus_be=0010, bus_wdata=0xABABABAB. SH addr 0x102, RD2=0x1234 → be=1100, wdata=0x12341234.
- LW addr 0x102 → addr_err one cycle, bus_req never asserted, mem_stall=0. SH addr 0x101 → same.
- LW with bus_ack never asserted, TIMEOUT=16 → bus_req high 16 cycles, bus_err one pulse, load_data=0, then DONE, then IDLE.
- rst asserted in BUSY on the 3rd wait cycle → next cycle bus_req=0, mem_stall=0, state IDLE. An ack the following cycle does not change load_data.
